wb8_master: RTL and testbench

//   Single-outstanding Wishbone initiator for the 8-bit peripheral bus. Converts a

---
 rtl/wb8_pkg.sv | 16 +
 rtl/wb8_master.sv | 110 +++++++++++
 tb/tb_wb8_master.sv | 365 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb8_pkg.sv
// Shared types and constants for the 8-bit Wishbone peripheral bus.
// Imported by wb8_master and anything that talks to wb8 slaves.
package wb8_pkg;

    localparam int WB8_DATA_W = 8;

    // Read data returned with an error response (and for every write)
    localparam logic [WB8_DATA_W-1:0] WB8_ERR_DAT = 8'h00;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } wb8_state_t;

endpackage

// File: rtl/wb8_master.sv
// Single-outstanding Wishbone initiator: one valid/ready request becomes one
// classic bus cycle, answered on a valid/ready response stream (data or timeout).
module wb8_master
    import wb8_pkg::*;
#(
    parameter int ADDR_WIDTH     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  I_wb_clk,
    input  logic                  I_reset_n,
    input  logic                  I_req_valid,
    output logic                  O_req_ready,
    input  logic [ADDR_WIDTH-1:0] I_req_adr,
    input  logic [WB8_DATA_W-1:0] I_req_dat,
    input  logic                  I_req_we,
    output logic                  O_rsp_valid,
    input  logic                  I_rsp_ready,
    output logic [WB8_DATA_W-1:0] O_rsp_dat,
    output logic                  O_rsp_err,
    output logic                  O_wb_cyc,
    output logic                  O_wb_stb,
    output logic                  O_wb_we,
    output logic [ADDR_WIDTH-1:0] O_wb_adr,
    output logic [WB8_DATA_W-1:0] O_wb_dat,
    input  logic                  I_wb_ack,
    input  logic [WB8_DATA_W-1:0] I_wb_dat
);

    // A zero timeout still needs a legal one-bit counter
    localparam int CNT_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb8_state_t       state;
    wb8_state_t       state_next;
    logic [CNT_W-1:0] count;
    logic             timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (count == CNT_LAST);

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Ack beats a simultaneous timeout; both end the bus cycle
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (I_req_valid)             state_next = BUS;
            BUS:     if (I_wb_ack || timeout_hit) state_next = RESP;
            RESP:    if (I_rsp_ready)             state_next = IDLE;
            default:                              state_next = IDLE;
        endcase
    end

    // Strobe decoded straight from state so reset drops it without waiting for a clock
    always_comb begin
        O_req_ready = 1'b0;
        O_wb_stb    = 1'b0;
        O_rsp_valid = 1'b0;
        case (state)
            IDLE:    O_req_ready = 1'b1;
            BUS:     O_wb_stb    = 1'b1;
            RESP:    O_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign O_wb_cyc = O_wb_stb;

    always_ff @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            O_wb_adr  <= '0;
            O_wb_dat  <= '0;
            O_wb_we   <= 1'b0;
            O_rsp_dat <= '0;
            O_rsp_err <= 1'b0;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (I_req_valid) begin
                        O_wb_adr <= I_req_adr;
                        O_wb_dat <= I_req_we ? I_req_dat : '0;
                        O_wb_we  <= I_req_we;
                        count    <= '0;
                    end
                end
                BUS: begin
                    if (I_wb_ack) begin
                        O_rsp_dat <= O_wb_we ? '0 : I_wb_dat;
                        O_rsp_err <= 1'b0;
                    end else if (timeout_hit) begin
                        O_rsp_dat <= WB8_ERR_DAT;
                        O_rsp_err <= 1'b1;
                    end else if (count != CNT_MAX) begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_wb8_master.sv
// Bench for wb8_master with a GPIO-style registered-ack slave and a response scoreboard.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_wb8_master;

    localparam int AW = 2;
    localparam int TO = 4;

    typedef struct {
        logic [7:0] dat;
        logic       err;
    } rsp_t;

    logic          I_wb_clk = 1'b0;
    logic          I_reset_n = 1'b0;
    logic          I_req_valid = 1'b0;
    logic          O_req_ready;
    logic [AW-1:0] I_req_adr = '0;
    logic [7:0]    I_req_dat = '0;
    logic          I_req_we = 1'b0;
    logic          O_rsp_valid;
    logic          I_rsp_ready = 1'b1;
    logic [7:0]    O_rsp_dat;
    logic          O_rsp_err;
    logic          O_wb_cyc;
    logic          O_wb_stb;
    logic          O_wb_we;
    logic [AW-1:0] O_wb_adr;
    logic [7:0]    O_wb_dat;
    logic          I_wb_ack;
    logic [7:0]    I_wb_dat;

    int   total = 0;
    int   bad = 0;
    int   cycle = 0;
    int   stb_high = 0;
    int   stb_pulses = 0;
    logic prev_stb = 1'b0;
    logic accepted = 1'b0;
    int   last_accept = 0;
    rsp_t exp_q[$];
    logic [7:0] model_mem [4];

    logic       silent = 1'b0;
    logic       slave_ack;
    logic [7:0] slave_rdat;
    logic [7:0] slave_mem [4];

    always #5 I_wb_clk = ~I_wb_clk;

    wb8_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .I_wb_clk    (I_wb_clk),
        .I_reset_n   (I_reset_n),
        .I_req_valid (I_req_valid),
        .O_req_ready (O_req_ready),
        .I_req_adr   (I_req_adr),
        .I_req_dat   (I_req_dat),
        .I_req_we    (I_req_we),
        .O_rsp_valid (O_rsp_valid),
        .I_rsp_ready (I_rsp_ready),
        .O_rsp_dat   (O_rsp_dat),
        .O_rsp_err   (O_rsp_err),
        .O_wb_cyc    (O_wb_cyc),
        .O_wb_stb    (O_wb_stb),
        .O_wb_we     (O_wb_we),
        .O_wb_adr    (O_wb_adr),
        .O_wb_dat    (O_wb_dat),
        .I_wb_ack    (I_wb_ack),
        .I_wb_dat    (I_wb_dat)
    );

    // Slave registers its ack from stb, so ack is one cycle late and a single pulse
    always @(posedge I_wb_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            slave_ack  <= 1'b0;
            slave_rdat <= 8'h00;
        end else begin
            slave_ack <= O_wb_stb && !slave_ack && !silent;
            if (O_wb_stb && !slave_ack && !silent) begin
                if (O_wb_we) slave_mem[O_wb_adr] <= O_wb_dat;
                slave_rdat <= slave_mem[O_wb_adr];
            end
        end
    end

    assign I_wb_ack = slave_ack;
    assign I_wb_dat = slave_rdat;

    initial begin
        for (int i = 0; i < 4; i++) begin
            slave_mem[i] = 8'h00;
            model_mem[i] = 8'h00;
        end
    end

    // One clock: sample and score at the falling edge, return just after the rising edge
    task automatic tick();
        rsp_t e;
        @(negedge I_wb_clk);
        accepted = I_reset_n && I_req_valid && O_req_ready;
        if (I_reset_n) begin
            total++;
            if (O_wb_cyc !== O_wb_stb) begin
                bad++;
                $display("[TB] FAIL cyc_eq_stb: cyc=%b stb=%b", O_wb_cyc, O_wb_stb);
            end
            if (O_wb_stb) stb_high++;
            if (O_wb_stb && !prev_stb) stb_pulses++;
            if (O_rsp_valid && I_rsp_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_rsp: dat=%h err=%b with empty scoreboard",
                             O_rsp_dat, O_rsp_err);
                end else begin
                    e = exp_q.pop_front();
                    if ({O_rsp_dat, O_rsp_err} !== {e.dat, e.err}) begin
                        bad++;
                        $display("[TB] FAIL rsp: got dat=%h err=%b, expected dat=%h err=%b",
                                 O_rsp_dat, O_rsp_err, e.dat, e.err);
                    end
                end
            end
        end
        prev_stb = O_wb_stb;
        @(posedge I_wb_clk);
        #1;
        cycle++;
    endtask

    task automatic reset_stats();
        stb_high   = 0;
        stb_pulses = 0;
    endtask

    // Holds the request until accepted, then pushes the expected response
    task automatic issue(input logic [AW-1:0] adr, input logic [7:0] dat,
                         input logic we, input logic expect_err);
        rsp_t e;
        int   n;
        I_req_valid = 1'b1;
        I_req_adr   = adr;
        I_req_dat   = dat;
        I_req_we    = we;
        n = 0;
        accepted = 1'b0;
        while (!accepted && n < 50) begin
            tick();
            n++;
        end
        I_req_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("[TB] FAIL req_accept: not accepted after %0d cycles, required within 50", n);
        end else begin
            if (we && !expect_err) model_mem[adr] = dat;
            e.err = expect_err;
            e.dat = (we || expect_err) ? 8'h00 : model_mem[adr];
            exp_q.push_back(e);
            last_accept = cycle;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !O_req_ready) && n < 100) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || !O_req_ready) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: %0d responses outstanding, req_ready=%b, required 0 and 1",
                     exp_q.size(), O_req_ready);
        end
    endtask

    task automatic test_reset();
        I_reset_n = 1'b0;
        repeat (3) @(posedge I_wb_clk);
        #1;
        total++;
        if (O_req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_req_ready: got %b, required 1", O_req_ready);
        end
        total++;
        if ({O_rsp_valid, O_rsp_err, O_rsp_dat, O_wb_cyc, O_wb_stb, O_wb_we, O_wb_adr, O_wb_dat}
            !== 23'd0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h, required all zero",
                     {O_rsp_valid, O_rsp_err, O_rsp_dat, O_wb_cyc, O_wb_stb, O_wb_we,
                      O_wb_adr, O_wb_dat});
        end
        I_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read_adr1();
        reset_stats();
        issue(2'd1, 8'hFF, 1'b1, 1'b0);
        issue(2'd1, 8'h00, 1'b0, 1'b0);
        wait_done();
        total++;
        if (stb_pulses !== 2) begin
            bad++;
            $display("[TB] FAIL adr1_stb_pulses: got %0d, required 2", stb_pulses);
        end
        total++;
        if (stb_high !== 4) begin
            bad++;
            $display("[TB] FAIL adr1_stb_cycles: got %0d, required 4", stb_high);
        end
    endtask

    task automatic test_write_read_adr0();
        issue(2'd0, 8'h5A, 1'b1, 1'b0);
        total++;
        if ({O_wb_stb, O_wb_we, O_wb_adr, O_wb_dat} !== {1'b1, 1'b1, 2'd0, 8'h5A}) begin
            bad++;
            $display("[TB] FAIL write_bus: got stb=%b we=%b adr=%0d dat=%h, required 1 1 0 5a",
                     O_wb_stb, O_wb_we, O_wb_adr, O_wb_dat);
        end
        wait_done();
        issue(2'd0, 8'hA5, 1'b0, 1'b0);
        total++;
        if ({O_wb_stb, O_wb_we, O_wb_dat} !== {1'b1, 1'b0, 8'h00}) begin
            bad++;
            $display("[TB] FAIL read_bus: got stb=%b we=%b dat=%h, required 1 0 00",
                     O_wb_stb, O_wb_we, O_wb_dat);
        end
        wait_done();
    endtask

    task automatic test_timeout();
        silent = 1'b1;
        reset_stats();
        issue(2'd2, 8'h00, 1'b0, 1'b1);
        wait_done();
        silent = 1'b0;
        total++;
        if (stb_high !== TO) begin
            bad++;
            $display("[TB] FAIL timeout_stb_cycles: got %0d, required %0d", stb_high, TO);
        end
        total++;
        if (stb_pulses !== 1) begin
            bad++;
            $display("[TB] FAIL timeout_stb_pulses: got %0d, required 1", stb_pulses);
        end
    endtask

    task automatic test_backpressure();
        int n;
        reset_stats();
        I_rsp_ready = 1'b0;
        issue(2'd1, 8'h00, 1'b0, 1'b0);
        n = 0;
        while (!O_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        total++;
        if (O_rsp_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_rsp_valid: got %b, required 1 within 20 cycles", O_rsp_valid);
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if ({O_rsp_valid, O_rsp_dat, O_rsp_err, O_req_ready, O_wb_stb}
                !== {1'b1, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
                bad++;
                $display("[TB] FAIL bp_hold: got valid=%b dat=%h err=%b req_ready=%b stb=%b, required 1 ff 0 0 0",
                         O_rsp_valid, O_rsp_dat, O_rsp_err, O_req_ready, O_wb_stb);
            end
            tick();
        end
        I_rsp_ready = 1'b1;
        wait_done();
        total++;
        if (stb_pulses !== 1) begin
            bad++;
            $display("[TB] FAIL bp_stb_pulses: got %0d, required 1", stb_pulses);
        end
    endtask

    task automatic test_back_to_back();
        int acc [4];
        reset_stats();
        I_rsp_ready = 1'b1;
        issue(2'd3, 8'h11, 1'b1, 1'b0);
        acc[0] = last_accept;
        issue(2'd3, 8'h00, 1'b0, 1'b0);
        acc[1] = last_accept;
        issue(2'd2, 8'hC3, 1'b1, 1'b0);
        acc[2] = last_accept;
        issue(2'd2, 8'h00, 1'b0, 1'b0);
        acc[3] = last_accept;
        wait_done();
        for (int i = 1; i < 4; i++) begin
            total++;
            if (acc[i] - acc[i-1] !== 4) begin
                bad++;
                $display("[TB] FAIL b2b_cadence: gap %0d is %0d cycles, required 4",
                         i, acc[i] - acc[i-1]);
            end
        end
        total++;
        if ({stb_pulses, stb_high} !== {32'd4, 32'd8}) begin
            bad++;
            $display("[TB] FAIL b2b_stb: got pulses=%0d cycles=%0d, required 4 and 8",
                     stb_pulses, stb_high);
        end
    endtask

    task automatic test_reset_mid_bus();
        silent = 1'b1;
        issue(2'd2, 8'h00, 1'b0, 1'b1);
        tick();
        #2;
        I_reset_n = 1'b0;
        #1;
        total++;
        if ({O_wb_stb, O_wb_cyc, O_rsp_valid, O_req_ready} !== 4'b0001) begin
            bad++;
            $display("[TB] FAIL midbus_reset: got stb=%b cyc=%b rsp_valid=%b req_ready=%b, required 0 0 0 1",
                     O_wb_stb, O_wb_cyc, O_rsp_valid, O_req_ready);
        end
        exp_q.delete();
        @(posedge I_wb_clk);
        @(posedge I_wb_clk);
        #1;
        I_reset_n = 1'b1;
        silent = 1'b0;
        tick();
        total++;
        if ({O_req_ready, O_wb_stb} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL release_idle: got req_ready=%b stb=%b, required 1 0",
                     O_req_ready, O_wb_stb);
        end
        issue(2'd3, 8'h00, 1'b0, 1'b0);
        wait_done();
    endtask

    initial begin
        test_reset();
        test_write_read_adr1();
        test_write_read_adr0();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
